// File: rtl/execute_if.sv
// Decode->execute, execute->memory and execute->fetch signals of the uRISC execute stage.
// master: the side driving decoded instructions and memory back-pressure.
// slave:  the execute stage itself.
interface execute_if #(
    parameter int DW   = 16,
    parameter int UOPW = 26
);
    logic            execute_valid_idix_p1;
    logic [4:0]      opcode_idix_p1;
    logic [1:0]      func_idix_p1;
    logic [2:0]      rd_idix_p1;
    logic [DW-1:0]   rs_val_idix_p1;
    logic [DW-1:0]   rt_val_idix_p1;
    logic [DW-1:0]   imm_idix_p1;
    logic [DW-1:0]   pc_inc_idix_p1;
    logic [UOPW-1:0] uop_cnt_idix_p1;
    logic            stall_memix_p1;

    logic [DW-1:0]   result_ixmem_p1;
    logic [DW-1:0]   st_data_ixmem_p1;
    logic [2:0]      rd_ixmem_p1;
    logic            wr_en_ixmem_p1;
    logic            ld_ixmem_p1;
    logic            st_ixmem_p1;
    logic            valid_ixmem_p1;
    logic [UOPW-1:0] uop_cnt_ixmem_p1;
    logic            redirect_ixif_p1;
    logic [DW-1:0]   redirect_pc_ixif_p1;
    logic            stall_ixid_p1;

    modport master (
        output execute_valid_idix_p1, opcode_idix_p1, func_idix_p1, rd_idix_p1,
               rs_val_idix_p1, rt_val_idix_p1, imm_idix_p1, pc_inc_idix_p1,
               uop_cnt_idix_p1, stall_memix_p1,
        input  result_ixmem_p1, st_data_ixmem_p1, rd_ixmem_p1, wr_en_ixmem_p1,
               ld_ixmem_p1, st_ixmem_p1, valid_ixmem_p1, uop_cnt_ixmem_p1,
               redirect_ixif_p1, redirect_pc_ixif_p1, stall_ixid_p1
    );

    modport slave (
        input  execute_valid_idix_p1, opcode_idix_p1, func_idix_p1, rd_idix_p1,
               rs_val_idix_p1, rt_val_idix_p1, imm_idix_p1, pc_inc_idix_p1,
               uop_cnt_idix_p1, stall_memix_p1,
        output result_ixmem_p1, st_data_ixmem_p1, rd_ixmem_p1, wr_en_ixmem_p1,
               ld_ixmem_p1, st_ixmem_p1, valid_ixmem_p1, uop_cnt_ixmem_p1,
               redirect_ixif_p1, redirect_pc_ixif_p1, stall_ixid_p1
    );
endinterface

// File: rtl/execute.sv
// uRISC execute stage: ALU/shift/compare/address evaluation, branch and jump
// resolution with fetch redirect, and the execute->memory pipeline register.
module execute #(
    parameter int DW   = 16,
    parameter int UOPW = 26
) (
    input logic       clk,
    input logic       rst,
    execute_if.slave  bus
);

    typedef enum logic [4:0] {
        OP_J     = 5'b00100, OP_JR    = 5'b00101, OP_JAL   = 5'b00110, OP_JALR  = 5'b00111,
        OP_ADDI  = 5'b01000, OP_SUBI  = 5'b01001, OP_XORI  = 5'b01010, OP_ANDNI = 5'b01011,
        OP_BEQZ  = 5'b01100, OP_BNEZ  = 5'b01101, OP_BLTZ  = 5'b01110, OP_BGEZ  = 5'b01111,
        OP_ST    = 5'b10000, OP_LD    = 5'b10001, OP_SLBI  = 5'b10010, OP_STU   = 5'b10011,
        OP_ROLI  = 5'b10100, OP_SLLI  = 5'b10101, OP_RORI  = 5'b10110, OP_SRLI  = 5'b10111,
        OP_LBI   = 5'b11000, OP_BTR   = 5'b11001, OP_SHR   = 5'b11010, OP_ALR   = 5'b11011,
        OP_SEQ   = 5'b11100, OP_SLT   = 5'b11101, OP_SLE   = 5'b11110, OP_SCO   = 5'b11111
    } opcode_e;

    // kind: 00 a+b, 01 b-a, 10 a^b, 11 a&~b (shared by I-type and R-type encodings)
    function automatic logic [DW-1:0] arith(input logic [1:0] kind,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (kind)
            2'b00:   r = a + b;
            2'b01:   r = b - a;
            2'b10:   r = a ^ b;
            default: r = a & ~b;
        endcase
        return r;
    endfunction

    // kind: 00 rotate left, 01 shift left, 10 rotate right, 11 shift right logical
    function automatic logic [DW-1:0] shift(input logic [1:0] kind,
                                            input logic [DW-1:0] v, input logic [3:0] amt);
        logic [2*DW-1:0] dl;
        logic [2*DW-1:0] dr;
        logic [DW-1:0]   r;
        dl = {v, v} << amt;
        dr = {v, v} >> amt;
        case (kind)
            2'b00:   r = dl[2*DW-1:DW];
            2'b01:   r = v << amt;
            2'b10:   r = dr[DW-1:0];
            default: r = v >> amt;
        endcase
        return r;
    endfunction

    opcode_e       op;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [DW-1:0] imm;
    logic [DW-1:0] result;
    logic [DW-1:0] st_data;
    logic [DW-1:0] target;
    logic [DW:0]   sco_sum;
    logic          wr_class;
    logic          ld;
    logic          st;
    logic          taken;
    logic          squash;
    logic          live;

    assign op      = opcode_e'(bus.opcode_idix_p1);
    assign rs      = bus.rs_val_idix_p1;
    assign rt      = bus.rt_val_idix_p1;
    assign imm     = bus.imm_idix_p1;
    assign sco_sum = {1'b0, rs} + {1'b0, rt};

    // A redirect in flight marks the instruction now at the input as wrong-path.
    assign squash = bus.redirect_ixif_p1;
    assign live   = bus.execute_valid_idix_p1 && !squash;

    assign bus.stall_ixid_p1 = bus.stall_memix_p1;

    // Decode the opcode class and evaluate result, store data and control-flow target.
    always_comb begin
        result   = '0;
        st_data  = '0;
        wr_class = 1'b0;
        ld       = 1'b0;
        st       = 1'b0;
        taken    = 1'b0;
        target   = bus.pc_inc_idix_p1 + imm;
        case (op)
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
                result   = arith(bus.opcode_idix_p1[1:0], rs, imm);
                wr_class = 1'b1;
            end
            OP_ALR: begin
                result   = arith(bus.func_idix_p1, rs, rt);
                wr_class = 1'b1;
            end
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                result   = shift(bus.opcode_idix_p1[1:0], rs, imm[3:0]);
                wr_class = 1'b1;
            end
            OP_SHR: begin
                result   = shift(bus.func_idix_p1, rs, rt[3:0]);
                wr_class = 1'b1;
            end
            OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                case (op)
                    OP_SEQ:  result[0] = (rs == rt);
                    OP_SLT:  result[0] = ($signed(rs) <  $signed(rt));
                    OP_SLE:  result[0] = ($signed(rs) <= $signed(rt));
                    default: result[0] = sco_sum[DW];
                endcase
                wr_class = 1'b1;
            end
            OP_LBI: begin
                result   = imm;
                wr_class = 1'b1;
            end
            OP_SLBI: begin
                result   = (rs << 8) | {{(DW-8){1'b0}}, imm[7:0]};
                wr_class = 1'b1;
            end
            OP_BTR: begin
                for (int unsigned i = 0; i < DW; i++) begin
                    result[i] = rs[DW-1-i];
                end
                wr_class = 1'b1;
            end
            OP_LD: begin
                result   = rs + imm;
                ld       = 1'b1;
                wr_class = 1'b1;
            end
            OP_ST, OP_STU: begin
                result   = rs + imm;
                st_data  = rt;
                st       = 1'b1;
                wr_class = (op == OP_STU);
            end
            OP_BEQZ: taken = (rs == '0);
            OP_BNEZ: taken = (rs != '0);
            OP_BLTZ: taken = rs[DW-1];
            OP_BGEZ: taken = !rs[DW-1];
            OP_J:    taken = 1'b1;
            OP_JR: begin
                taken  = 1'b1;
                target = rs + imm;
            end
            OP_JAL: begin
                taken    = 1'b1;
                result   = bus.pc_inc_idix_p1;
                wr_class = 1'b1;
            end
            OP_JALR: begin
                taken    = 1'b1;
                target   = rs + imm;
                result   = bus.pc_inc_idix_p1;
                wr_class = 1'b1;
            end
            default: ;
        endcase
    end

    // ixmem pipeline register and fetch redirect; memory stall freezes the register and kills redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result_ixmem_p1     <= '0;
            bus.st_data_ixmem_p1    <= '0;
            bus.rd_ixmem_p1         <= '0;
            bus.wr_en_ixmem_p1      <= 1'b0;
            bus.ld_ixmem_p1         <= 1'b0;
            bus.st_ixmem_p1         <= 1'b0;
            bus.valid_ixmem_p1      <= 1'b0;
            bus.uop_cnt_ixmem_p1    <= '0;
            bus.redirect_ixif_p1    <= 1'b0;
            bus.redirect_pc_ixif_p1 <= '0;
        end else if (bus.stall_memix_p1) begin
            bus.redirect_ixif_p1 <= 1'b0;
        end else begin
            bus.result_ixmem_p1  <= result;
            bus.st_data_ixmem_p1 <= st_data;
            bus.rd_ixmem_p1      <= bus.rd_idix_p1;
            bus.wr_en_ixmem_p1   <= live && wr_class;
            bus.ld_ixmem_p1      <= live && ld;
            bus.st_ixmem_p1      <= live && st;
            bus.valid_ixmem_p1   <= live;
            bus.uop_cnt_ixmem_p1 <= bus.uop_cnt_idix_p1;
            bus.redirect_ixif_p1 <= live && taken;
            if (live && taken) begin
                bus.redirect_pc_ixif_p1 <= target;
            end
        end
    end

endmodule
